// File: rtl/lsu_pkg.sv
// Shared size codes, FSM state encoding and request legality check for the load/store unit.
// Pure definitions: no latency, no backpressure.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_t;

  // Reserved size, natural-alignment violation, or address past the end of memory.
  function automatic logic req_error(input logic [1:0]  size,
                                     input logic [31:0] addr,
                                     input logic [31:0] mem_bytes);
    logic misalign;
    misalign = ((size == SZ_HALF) && addr[0]) ||
               ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    return (size == SZ_RSVD) || misalign || (addr >= mem_bytes);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Big-endian lane steering: extract+extend for loads, lane merge for sub-word stores.
// Purely combinational; no state, no backpressure.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  input  logic [31:0] mword,
  output logic [31:0] ext,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword[7:0];
    case (off)
      2'd0:    byte_sel = rword[31:24];
      2'd1:    byte_sel = rword[23:16];
      2'd2:    byte_sel = rword[15:8];
      default: byte_sel = rword[7:0];
    endcase
    half_sel = off[1] ? rword[15:0] : rword[31:16];

    ext = rword;
    case (size)
      SZ_BYTE: ext = sgn ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      SZ_HALF: ext = sgn ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
      default: ext = rword;
    endcase
  end

  // Start from the previously read word and overwrite only the addressed lane(s).
  always_comb begin
    merged = mword;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    merged[31:24] = wdata[7:0];
          2'd1:    merged[23:16] = wdata[7:0];
          2'd2:    merged[15:8]  = wdata[7:0];
          default: merged[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) merged[15:0]  = wdata[15:0];
        else        merged[31:16] = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store master to a word-wide big-endian memory (RMW for sub-word stores).
// Response 1 (error), 2 (load / word store) or 3 (sub-word store) cycles after accept; req_ready only in IDLE, response unthrottled.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] data_q, data_d;

  logic [31:0] lane_ext;
  logic [31:0] lane_merged;

  lsu_lane u_lane (
    .off    (addr_q[1:0]),
    .size   (size_q),
    .sgn    (signed_q),
    .rword  (mem_rdata),
    .wdata  (wdata_q),
    .mword  (data_q),
    .ext    (lane_ext),
    .merged (lane_merged)
  );

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = req_error(req_size, req_addr, 32'(MEM_BYTES));
          data_d   = '0;
          if (err_d)                                 state_d = RESP;
          else if (req_write && req_size == SZ_WORD) state_d = WR;
          else                                       state_d = RD;
        end
      end
      RD: begin
        // Stores keep the raw word for merging; loads keep the extended result.
        data_d  = write_q ? mem_rdata : lane_ext;
        state_d = write_q ? WR : RESP;
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      data_q   <= data_d;
    end
  end

  // Gating with rst_n keeps ready low while reset is held even though the state is already IDLE.
  assign req_ready  = rst_n && (state_q == IDLE);
  assign mem_read   = (state_q == RD);
  assign mem_write  = (state_q == WR);
  assign mem_addr   = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wdata  = mem_write ? lane_merged : '0;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !write_q && !err_q) ? data_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array reference model, directed and randomized requests.
module tb_load_store_unit;

  localparam int MEM_BYTES = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [7:0] mem     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  logic [6:0] ma;

  int vectors = 0;
  int miscompares = 0;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory environment: combinational read, write committed on the negedge.
  assign ma = mem_addr[6:0];
  always_comb begin
    mem_rdata = '0;
    if (mem_read && mem_addr < MEM_BYTES)
      mem_rdata = {mem[ma], mem[ma + 7'd1], mem[ma + 7'd2], mem[ma + 7'd3]};
  end

  always @(negedge clk) begin
    if (mem_write && mem_addr < MEM_BYTES) begin
      mem[ma]         <= mem_wdata[31:24];
      mem[ma + 7'd1]  <= mem_wdata[23:16];
      mem[ma + 7'd2]  <= mem_wdata[15:8];
      mem[ma + 7'd3]  <= mem_wdata[7:0];
    end
  end

  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) ||
           (sz == 2'b10 && a % 4 != 0) || (a >= MEM_BYTES);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    logic [6:0]         i;
    logic [15:0]        h;
    logic signed [31:0] s;
    i = a[6:0];
    if (sz == 2'b00) begin
      s = $signed(ref_mem[i]);
      return sg ? s : {24'b0, ref_mem[i]};
    end
    if (sz == 2'b01) begin
      h = {ref_mem[i], ref_mem[i + 7'd1]};
      s = $signed(h);
      return sg ? s : {16'b0, h};
    end
    return {ref_mem[i], ref_mem[i + 7'd1], ref_mem[i + 7'd2], ref_mem[i + 7'd3]};
  endfunction

  task automatic scramble_inputs();
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // One complete transaction, checked against the reference model.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got, output logic [31:0] wr_word);
    logic        e;
    int          exp_lat, exp_rd, exp_wr, lat, nrd, nwr, both, leak, waited;
    logic [31:0] exp_rdata, exp_wdata, wa, seen_waddr, seen_raddr;
    logic [6:0]  i;
    bit          done;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    waited = 0;
    while (!req_ready && waited < 8) begin @(negedge clk); waited++; end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL %s accept: req_ready=%0b, required 1", tag, req_ready);
    end
    e  = ref_err(sz, a);
    wa = a & ~32'd3;
    i  = a[6:0];
    exp_lat   = e ? 1 : (w && sz != 2'b10) ? 3 : 2;
    exp_rd    = (!e && !(w && sz == 2'b10)) ? 1 : 0;
    exp_wr    = (!e && w) ? 1 : 0;
    exp_rdata = (!e && !w) ? ref_load(sz, sg, a) : 32'd0;
    exp_wdata = 32'd0;
    if (!e && w) begin
      case (sz)
        2'b00:   ref_mem[i] = wd[7:0];
        2'b01:   begin ref_mem[i] = wd[15:8]; ref_mem[i + 7'd1] = wd[7:0]; end
        default: begin
          ref_mem[i] = wd[31:24]; ref_mem[i + 7'd1] = wd[23:16];
          ref_mem[i + 7'd2] = wd[15:8]; ref_mem[i + 7'd3] = wd[7:0];
        end
      endcase
      exp_wdata = {ref_mem[wa[6:0]], ref_mem[wa[6:0] + 7'd1], ref_mem[wa[6:0] + 7'd2], ref_mem[wa[6:0] + 7'd3]};
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scramble_inputs();
    lat = 0; nrd = 0; nwr = 0; both = 0; leak = 0; done = 0;
    wr_word = 32'd0; seen_waddr = 32'd0; seen_raddr = 32'd0;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
      if (mem_read)  begin nrd++; seen_raddr = mem_addr; end
      if (mem_write) begin nwr++; seen_waddr = mem_addr; wr_word = mem_wdata; end
      if (mem_read && mem_write) both++;
      if (!mem_write && mem_wdata !== 32'd0) leak++;
      if (resp_valid) done = 1;
    end
    got = resp_rdata;
    vectors++;
    if (lat !== exp_lat || !done) begin
      miscompares++; $display("FAIL %s latency: got %0d (resp seen=%0b), required %0d", tag, lat, done, exp_lat);
    end
    vectors++;
    if (resp_err !== e) begin
      miscompares++; $display("FAIL %s resp_err: got %0b, required %0b", tag, resp_err, e);
    end
    vectors++;
    if (resp_rdata !== exp_rdata) begin
      miscompares++; $display("FAIL %s resp_rdata: got %08h, required %08h", tag, resp_rdata, exp_rdata);
    end
    vectors++;
    if (nrd !== exp_rd || nwr !== exp_wr || both !== 0 || leak !== 0) begin
      miscompares++;
      $display("FAIL %s mem strobes: reads %0d writes %0d both %0d wdata_leak %0d, required reads %0d writes %0d both 0 leak 0",
               tag, nrd, nwr, both, leak, exp_rd, exp_wr);
    end
    if (exp_wr == 1) begin
      vectors++;
      if (wr_word !== exp_wdata || seen_waddr !== wa) begin
        miscompares++;
        $display("FAIL %s write: mem_wdata %08h @ %08h, required %08h @ %08h", tag, wr_word, seen_waddr, exp_wdata, wa);
      end
    end
    if (exp_rd == 1) begin
      vectors++;
      if (seen_raddr !== wa) begin
        miscompares++; $display("FAIL %s read addr: got %08h, required %08h", tag, seen_raddr, wa);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0;
    scramble_inputs();
    for (int k = 0; k < MEM_BYTES; k++) begin
      logic [7:0] v;
      v = 8'($urandom);
      mem[k] <= v;
      ref_mem[k] = v;
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset ctrl: ready %0b rv %0b err %0b rd %0b wr %0b, required all 0",
               req_ready, resp_valid, resp_err, mem_read, mem_write);
    end
    vectors++;
    if ({resp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
      miscompares++;
      $display("FAIL reset data: rdata %08h addr %08h wdata %08h, required 0", resp_rdata, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset release ready: got %0b, required 1", req_ready);
    end
  endtask

  task automatic test_word_store_load();
    logic [31:0] got, ww;
    do_req("sw_0x10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, got, ww);
    vectors++;
    if (ww !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL sw_word: mem_wdata %08h, required deadbeef", ww);
    end
    do_req("lw_0x10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got, ww);
    vectors++;
    if (got !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL lw_value: got %08h, required deadbeef", got);
    end
  endtask

  task automatic test_byte_rmw();
    logic [31:0] got, ww;
    do_req("sb_0x12", 1'b1, 2'b00, 1'b0, 32'h12, 32'hAB12_3455, got, ww);
    vectors++;
    if (ww !== 32'hDEAD55EF) begin
      miscompares++; $display("FAIL sb_merge: mem_wdata %08h, required dead55ef", ww);
    end
  endtask

  task automatic test_sign_ext();
    logic [31:0] got, ww;
    do_req("lb_0x10", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, got, ww);
    vectors++;
    if (got !== 32'hFFFFFFDE) begin miscompares++; $display("FAIL lb: got %08h, required ffffffde", got); end
    do_req("lbu_0x10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, got, ww);
    vectors++;
    if (got !== 32'h000000DE) begin miscompares++; $display("FAIL lbu: got %08h, required 000000de", got); end
    do_req("lh_0x12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, got, ww);
    vectors++;
    if (got !== 32'h000055EF) begin miscompares++; $display("FAIL lh12: got %08h, required 000055ef", got); end
    do_req("lh_0x10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, got, ww);
    vectors++;
    if (got !== 32'hFFFFDEAD) begin miscompares++; $display("FAIL lh10: got %08h, required ffffdead", got); end
  endtask

  task automatic test_errors();
    logic [31:0] got, ww;
    do_req("err_lw_0x11", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, got, ww);
    do_req("err_lh_0x13", 1'b0, 2'b01, 1'b1, 32'h13, 32'h0, got, ww);
    do_req("err_size11",  1'b0, 2'b11, 1'b0, 32'h20, 32'h0, got, ww);
    do_req("err_sw_0x80", 1'b1, 2'b10, 1'b0, 32'h80, 32'h12345678, got, ww);
    do_req("err_sh_0x7f", 1'b1, 2'b01, 1'b0, 32'h7F, 32'h1234, got, ww);
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    int          accepts, resps;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        sg, exp_ready;
    accepts = 0; resps = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      exp_ready = (cyc >= 9) || (cyc % 3 == 0);
      vectors++;
      if (req_ready !== exp_ready) begin
        miscompares++; $display("FAIL b2b ready cyc %0d: got %0b, required %0b", cyc, req_ready, exp_ready);
      end
      if (resp_valid) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++; $display("FAIL b2b extra resp cyc %0d: rdata %08h, required no response", cyc, resp_rdata);
        end else begin
          if (resp_rdata !== q[0] || resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b resp %0d: rdata %08h err %0b, required %08h err 0", resps, resp_rdata, resp_err, q[0]);
          end
          void'(q.pop_front());
        end
        resps++;
      end
      if (req_ready && accepts < 3) begin
        sz = 2'($urandom_range(0, 2));
        sg = 1'($urandom);
        a  = 32'($urandom_range(0, MEM_BYTES - 1));
        if (sz == 2'b01) a = a & ~32'd1;
        if (sz == 2'b10) a = a & ~32'd3;
        req_valid = 1'b1; req_write = 1'b0; req_size = sz; req_signed = sg; req_addr = a;
        q.push_back(ref_load(sz, sg, a));
        accepts++;
      end else begin
        scramble_inputs();
        req_valid = (accepts < 3);
      end
    end
    req_valid = 1'b0;
    vectors++;
    if (resps !== 3) begin
      miscompares++; $display("FAIL b2b count: got %0d responses, required 3", resps);
    end
  endtask

  task automatic test_reset_mid_wr();
    logic [31:0] got, ww, wd;
    wd = $urandom;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h21; req_wdata = wd;
    // The write is sampled before reset hits, so it lands in memory.
    ref_mem[7'h21] = wd[7:0];
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_read !== 1'b1) begin miscompares++; $display("FAIL rst_wr RD phase: mem_read %0b, required 1", mem_read); end
    @(negedge clk);
    vectors++;
    if (mem_write !== 1'b1) begin miscompares++; $display("FAIL rst_wr WR phase: mem_write %0b, required 1", mem_write); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready, resp_valid, mem_read, mem_write} !== 4'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_wr async: ready %0b rv %0b rd %0b wr %0b addr %08h wdata %08h, required all 0",
               req_ready, resp_valid, mem_read, mem_write, mem_addr, mem_wdata);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wr resp during reset: got %0b, required 0", resp_valid); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_wr after release: ready %0b rv %0b, required 1 0", req_ready, resp_valid);
    end
    do_req("rst_wr_lw", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, got, ww);
  endtask

  task automatic test_random();
    logic [31:0] got, ww, a;
    logic [1:0]  sz;
    for (int n = 0; n < 60; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(MEM_BYTES, 300)) : 32'($urandom_range(0, MEM_BYTES - 1));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a = a & ~32'd1;
        if (sz == 2'b10) a = a & ~32'd3;
      end
      do_req("rand", 1'($urandom), sz, 1'($urandom), a, $urandom, got, ww);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_sign_ext();
    test_errors();
    test_back_to_back();
    test_reset_mid_wr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
